piano_poly_tone_gen: RTL and testbench

//  Polyphonic square-wave note generator for the piano keyboard design; NUM_CH independent voices.

---
 rtl/piano_poly_tone_gen.sv | 211 +++++++++++++++++++++
 tb/tb_piano_poly_tone_gen.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/piano_poly_tone_gen.sv
// rtl/piano_poly_tone_gen.sv - polyphonic square-wave note generator with level mix and 1-bit speaker
//
// Purpose:
//   NUM_CH independent square-wave voices, each driven by a 7-bit note code
//   {octave[6:4], semitone[3:0]} (semitone 1..12 = C..B, 0 and 13..15 silent,
//   octaves above MAX_OCT silent). Half-period reload values are derived at
//   elaboration from CLK_HZ. Note changes take effect only at half-period
//   boundaries, so the waveform never glitches.
//
// Ports:
//   clk         in   1                   system clock, rising edge
//   reset       in   1                   synchronous, active-high, overrides all inputs
//   note_in     in   7*NUM_CH            note code per voice, voice i at [7*i+6:7*i]
//   note_valid  in   NUM_CH              1-cycle strobe capturing voice i's note code
//   mute        in   1                   gates all audio outputs low, phase keeps running
//   ch_wave     out  NUM_CH              per-voice square wave (gated by mute)
//   ch_active   out  NUM_CH              voice is playing a non-silent note
//   mix_level   out  $clog2(NUM_CH+1)    registered count of high ch_wave bits
//   speaker     out  1                   mixed 1-bit output
//
// Configuration macro:
//   PIANO_SD_MIX_EN  defined: first-order sigma-delta speaker, duty = mix_level/NUM_CH
//                    undefined: speaker is ch_wave[0] delayed by one cycle

module piano_poly_tone_gen #(
    parameter int CLK_HZ  = 50_000_000,
    parameter int NUM_CH  = 4,
    parameter int MAX_OCT = 4,
    parameter int CNT_W   = 20
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [7*NUM_CH-1:0]           note_in,
    input  logic [NUM_CH-1:0]             note_valid,
    input  logic                          mute,
    output logic [NUM_CH-1:0]             ch_wave,
    output logic [NUM_CH-1:0]             ch_active,
    output logic [$clog2(NUM_CH+1)-1:0]   mix_level,
    output logic                          speaker
);

    localparam int LVL_W = $clog2(NUM_CH + 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Half-period reload for a note. The case holds HP0+1 = CLK_HZ/f/2 for
    // octave 0; higher octaves halve that count before subtracting one, so
    // only a constant mux and a shifter are built.
    function automatic logic [CNT_W-1:0] half_period(input logic [6:0] code);
        logic [CNT_W-1:0] base;
        case (code[3:0])
            4'd1:    base = CNT_W'(CLK_HZ / 262 / 2);
            4'd2:    base = CNT_W'(CLK_HZ / 278 / 2);
            4'd3:    base = CNT_W'(CLK_HZ / 294 / 2);
            4'd4:    base = CNT_W'(CLK_HZ / 312 / 2);
            4'd5:    base = CNT_W'(CLK_HZ / 330 / 2);
            4'd6:    base = CNT_W'(CLK_HZ / 350 / 2);
            4'd7:    base = CNT_W'(CLK_HZ / 370 / 2);
            4'd8:    base = CNT_W'(CLK_HZ / 392 / 2);
            4'd9:    base = CNT_W'(CLK_HZ / 416 / 2);
            4'd10:   base = CNT_W'(CLK_HZ / 440 / 2);
            4'd11:   base = CNT_W'(CLK_HZ / 467 / 2);
            4'd12:   base = CNT_W'(CLK_HZ / 494 / 2);
            default: base = '0;
        endcase
        half_period = (base >> code[6:4]) - CNT_W'(1);
    endfunction

    function automatic logic is_silent(input logic [6:0] code);
        is_silent = (code[3:0] == 4'd0) || (code[3:0] > 4'd12) ||
                    (32'(code[6:4]) > MAX_OCT);
    endfunction

    logic [NUM_CH-1:0] wave_raw;
    logic [NUM_CH-1:0] gated;
    logic [LVL_W-1:0]  pop;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_voice
        state_t           state_q, state_d;
        logic [6:0]       cur_q, cur_d;
        logic [6:0]       pend_q, pend_d;
        logic             flag_q, flag_d;
        logic             wave_q, wave_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             consume;
        logic [6:0]       slice;

        assign slice = note_in[7*i +: 7];

        always_ff @(posedge clk) begin
            if (reset) begin
                state_q <= IDLE;
                cur_q   <= '0;
                pend_q  <= '0;
                flag_q  <= 1'b0;
                wave_q  <= 1'b0;
                cnt_q   <= '0;
            end else begin
                state_q <= state_d;
                cur_q   <= cur_d;
                pend_q  <= pend_d;
                flag_q  <= flag_d;
                wave_q  <= wave_d;
                cnt_q   <= cnt_d;
            end
        end

        always_comb begin
            state_d = state_q;
            cur_d   = cur_q;
            cnt_d   = cnt_q;
            wave_d  = wave_q;
            consume = 1'b0;
            case (state_q)
                IDLE: begin
                    if (flag_q) begin
                        consume = 1'b1;
                        if (!is_silent(pend_q)) begin
                            cur_d   = pend_q;
                            cnt_d   = half_period(pend_q);
                            wave_d  = 1'b0;
                            state_d = RUN;
                        end
                    end
                end
                RUN: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end else if (flag_q) begin
                        // Boundary with a queued note: switch here so the
                        // new pitch starts on a clean half-period.
                        consume = 1'b1;
                        cur_d   = pend_q;
                        if (is_silent(pend_q)) begin
                            wave_d  = 1'b0;
                            cnt_d   = '0;
                            state_d = IDLE;
                        end else begin
                            wave_d = ~wave_q;
                            cnt_d  = half_period(pend_q);
                        end
                    end else begin
                        wave_d = ~wave_q;
                        cnt_d  = half_period(cur_q);
                    end
                end
                default: state_d = IDLE;
            endcase

            // A strobe on a boundary cycle lands after the old pending note
            // was consumed, so the flag stays set for the next boundary.
            pend_d = note_valid[i] ? slice : pend_q;
            flag_d = note_valid[i] ? 1'b1 : (consume ? 1'b0 : flag_q);
        end

        assign wave_raw[i]  = wave_q;
        assign ch_active[i] = (state_q == RUN);
    end

    assign gated   = wave_raw & ~{NUM_CH{mute}};
    assign ch_wave = gated;

    always_comb begin
        pop = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            pop = pop + LVL_W'(gated[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mix_level <= '0;
        end else begin
            mix_level <= pop;
        end
    end

`ifdef PIANO_SD_MIX_EN
    localparam int ACC_W = $clog2(2 * NUM_CH);

    logic [ACC_W-1:0] acc_q;
    logic [ACC_W:0]   sd_sum;

    assign sd_sum = (ACC_W+1)'(acc_q) + (ACC_W+1)'(mix_level);

    always_ff @(posedge clk) begin
        if (reset || mute) begin
            acc_q   <= '0;
            speaker <= 1'b0;
        end else if (sd_sum >= (ACC_W+1)'(NUM_CH)) begin
            acc_q   <= ACC_W'(sd_sum - (ACC_W+1)'(NUM_CH));
            speaker <= 1'b1;
        end else begin
            acc_q   <= ACC_W'(sd_sum);
            speaker <= 1'b0;
        end
    end
`else
    always_ff @(posedge clk) begin
        if (reset) begin
            speaker <= 1'b0;
        end else begin
            speaker <= gated[0];
        end
    end
`endif

endmodule

// File: tb/tb_piano_poly_tone_gen.sv
// tb/tb_piano_poly_tone_gen.sv - scoreboard testbench for piano_poly_tone_gen

module tb_piano_poly_tone_gen;

    localparam int CLK_HZ  = 50_000;
    localparam int NUM_CH  = 4;
    localparam int MAX_OCT = 4;
    localparam int CNT_W   = 12;
    localparam int LVL_W   = $clog2(NUM_CH + 1);
    localparam int LIMIT   = 1000;

    logic                  clk = 1'b0;
    logic                  reset = 1'b1;
    logic                  mute = 1'b0;
    logic [7*NUM_CH-1:0]   note_in = '0;
    logic [NUM_CH-1:0]     note_valid = '0;
    logic [NUM_CH-1:0]     ch_wave;
    logic [NUM_CH-1:0]     ch_active;
    logic [LVL_W-1:0]      mix_level;
    logic                  speaker;

    piano_poly_tone_gen #(
        .CLK_HZ (CLK_HZ),
        .NUM_CH (NUM_CH),
        .MAX_OCT(MAX_OCT),
        .CNT_W  (CNT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .note_in   (note_in),
        .note_valid(note_valid),
        .mute      (mute),
        .ch_wave   (ch_wave),
        .ch_active (ch_active),
        .mix_level (mix_level),
        .speaker   (speaker)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    typedef struct {
        longint            t;
        logic [NUM_CH-1:0] wave;
        logic [NUM_CH-1:0] active;
        int                level;
        logic              spk;
    } exp_t;

    exp_t exp_q[$];

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Reference model: each playing voice is described by the absolute
    // cycle of its next half-period boundary rather than a down-counter.
    int freq_tab [12] = '{262, 278, 294, 312, 330, 350, 370, 392, 416, 440, 467, 494};

    function automatic int hp_of(input int code);
        int semi, oct, hp0;
        semi = code & 15;
        oct  = (code >> 4) & 7;
        hp0  = CLK_HZ / freq_tab[semi-1] / 2 - 1;
        return ((hp0 + 1) >> oct) - 1;
    endfunction

    function automatic bit silent(input int code);
        int semi, oct;
        semi = code & 15;
        oct  = (code >> 4) & 7;
        return (semi == 0) || (semi > 12) || (oct > MAX_OCT);
    endfunction

    bit     m_play [NUM_CH];
    bit     m_wave [NUM_CH];
    bit     m_flag [NUM_CH];
    int     m_cur  [NUM_CH];
    int     m_pend [NUM_CH];
    longint m_next [NUM_CH];
    int     m_level = 0;
    bit     m_spk = 0;
    int     m_acc = 0;
    longint t = 0;

    initial begin : model
        logic                r, mu;
        logic [NUM_CH-1:0]   nv;
        logic [7*NUM_CH-1:0] ni;
        logic [NUM_CH-1:0]   gated_pre;
        logic [NUM_CH-1:0]   wv, av;
        exp_t                e;
        int                  s;
        forever begin
            @(posedge clk);
            r  = reset;
            mu = mute;
            nv = note_valid;
            ni = note_in;
            t++;
            for (int v = 0; v < NUM_CH; v++) gated_pre[v] = m_wave[v] & ~mu;
            if (r) begin
                for (int v = 0; v < NUM_CH; v++) begin
                    m_play[v] = 0; m_wave[v] = 0; m_flag[v] = 0;
                    m_cur[v] = 0; m_pend[v] = 0; m_next[v] = 0;
                end
                m_level = 0; m_spk = 0; m_acc = 0;
            end else begin
`ifdef PIANO_SD_MIX_EN
                if (mu) begin
                    m_acc = 0; m_spk = 0;
                end else begin
                    s = m_acc + m_level;
                    if (s >= NUM_CH) begin m_acc = s - NUM_CH; m_spk = 1; end
                    else begin m_acc = s; m_spk = 0; end
                end
`else
                m_spk = gated_pre[0];
`endif
                m_level = $countones(gated_pre);
                for (int v = 0; v < NUM_CH; v++) begin
                    if (!m_play[v]) begin
                        if (m_flag[v]) begin
                            m_flag[v] = 0;
                            if (!silent(m_pend[v])) begin
                                m_play[v] = 1;
                                m_wave[v] = 0;
                                m_cur[v]  = m_pend[v];
                                m_next[v] = t + hp_of(m_cur[v]) + 1;
                            end
                        end
                    end else if (t == m_next[v]) begin
                        if (m_flag[v]) begin
                            m_flag[v] = 0;
                            m_cur[v]  = m_pend[v];
                        end
                        if (silent(m_cur[v])) begin
                            m_play[v] = 0;
                            m_wave[v] = 0;
                        end else begin
                            m_wave[v] = !m_wave[v];
                            m_next[v] = t + hp_of(m_cur[v]) + 1;
                        end
                    end
                    if (nv[v]) begin
                        m_pend[v] = int'(ni[7*v +: 7]);
                        m_flag[v] = 1;
                    end
                end
            end
            #3;
            for (int v = 0; v < NUM_CH; v++) begin
                wv[v] = m_wave[v] & ~mute;
                av[v] = m_play[v];
            end
            e.t = t; e.wave = wv; e.active = av; e.level = m_level; e.spk = m_spk;
            exp_q.push_back(e);
        end
    end

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                checks++;
                if (ch_wave !== e.wave || ch_active !== e.active ||
                    mix_level !== LVL_W'(e.level) || speaker !== e.spk) begin
                    failures++;
                    $display("FAIL cycle%0d actual wave=%b active=%b level=%0d spk=%b required wave=%b active=%b level=%0d spk=%b",
                             e.t, ch_wave, ch_active, mix_level, speaker,
                             e.wave, e.active, e.level, e.spk);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
        note_valid = '0;
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic strobe(input int v, input logic [6:0] code);
        note_in[7*v +: 7] = code;
        note_valid[v]     = 1'b1;
    endtask

    task automatic wait_wave0(input logic lvl, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (ch_wave[0] !== lvl && n < LIMIT);
    endtask

    initial begin : stimulus
        int n, total;
        logic [6:0] code;

        run(3);
        reset = 1'b0;
        step();

        // A at octave 0: HP = 50000/440/2 - 1 = 55, half-period 56 cycles.
        strobe(0, 7'h0A);
        step();
        n = 0;
        do begin step(); n++; end while (ch_active[0] !== 1'b1 && n < LIMIT);
        chk("active_latency", n, 1);
        wait_wave0(1'b1, n);
        chk("first_rise", n, 56);
        wait_wave0(1'b0, n);
        total = n;
        wait_wave0(1'b1, n);
        chk("period_a0", total + n, 112);

        // Octave change mid half-period: old half-period finishes, then 28.
        run(10);
        strobe(0, 7'h1A);
        wait_wave0(1'b0, n);
        chk("old_half_kept", n + 10, 56);
        wait_wave0(1'b1, n);
        chk("new_half", n, 28);

        // Two voices started together.
        reset = 1'b1; step(); reset = 1'b0;
        strobe(0, 7'h0A);
        strobe(1, 7'h0A);
        run(300);

        // Silent codes; ch1 stops at its next boundary.
        strobe(1, 7'h00);
        strobe(2, 7'h0D);
        strobe(3, 7'h50);
        run(150);
        chk("silent_ch1", ch_active[1], 0);
        chk("silent_ch23", ch_active[3:2], 0);
        strobe(2, 7'h00);
        run(20);

        // Mute mid-note; phase must carry on underneath.
        mute = 1'b1;
        run(1000);
        mute = 1'b0;
        run(200);

        // Reset with a pending strobe outstanding.
        strobe(0, 7'h13);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("reset_active", ch_active, 0);
        run(300);
        chk("pending_discarded", ch_active, 0);

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            for (int v = 0; v < NUM_CH; v++) begin
                if ($urandom_range(0, 15) == 0) begin
                    code[6:4] = 3'($urandom_range(0, 5));
                    code[3:0] = 4'($urandom_range(0, 13));
                    strobe(v, code);
                end
            end
            if ($urandom_range(0, 199) == 0) mute = ~mute;
            reset = ($urandom_range(0, 999) == 0);
            step();
        end
        reset = 1'b0;
        mute  = 1'b0;
        run(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
